// File: rtl/dw_window_gen_3x3_if.sv
// dw_window_gen_3x3_if: pixel stream in, 3x3xCH window stream out.
interface dw_window_gen_3x3_if #(
    parameter int CH    = 16,
    parameter int ACT_W = 8
);
    logic                     in_valid;
    logic                     in_sof;
    logic [CH*ACT_W-1:0]      in_pix;
    logic                     out_valid;
    logic [9*CH*ACT_W-1:0]    out_win;
    logic                     frame_done;
    modport master (output in_valid, in_sof, in_pix, input out_valid, out_win, frame_done);
    modport slave  (input in_valid, in_sof, in_pix, output out_valid, out_win, frame_done);
endinterface

// File: rtl/dw_window_gen_3x3.sv
// dw_window_gen_3x3: streaming stride-1 3x3xCH window generator with two line buffers.
module dw_window_gen_3x3 #(
    parameter int CH    = 16,
    parameter int ACT_W = 8,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input logic              clk,
    input logic              rst,
    dw_window_gen_3x3_if.slave bus
);
    localparam int PW = CH * ACT_W;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0]   col_q, col_d, col;
    logic [RW-1:0]   row_q, row_d, row;
    logic            col_wrap;
    logic [PW-1:0]   lb0_q [IMG_W];
    logic [PW-1:0]   lb1_q [IMG_W];
    logic [PW-1:0]   win_q [3][3];
    logic            out_valid_q, frame_done_q;
    logic [9*PW-1:0] win_flat;

    // A start-of-frame beat forces position (0,0) regardless of the counters.
    always_comb begin
        col      = bus.in_sof ? '0 : col_q;
        row      = bus.in_sof ? '0 : row_q;
        col_wrap = col == CW'(IMG_W - 1);
        col_d    = col_wrap ? '0 : col + 1'b1;
        row_d    = col_wrap ? (row == RW'(IMG_H - 1) ? '0 : row + 1'b1) : row;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            win_q        <= '{default: '0};
        end else begin
            out_valid_q  <= bus.in_valid && row >= RW'(2) && col >= CW'(2);
            frame_done_q <= bus.in_valid && row == RW'(IMG_H - 1) && col_wrap;
            if (bus.in_valid) begin
                col_q <= col_d;
                row_q <= row_d;
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= lb1_q[col];
                win_q[1][2] <= lb0_q[col];
                win_q[2][2] <= bus.in_pix;
            end
        end
    end

    // Line buffers hold no reset: every entry is rewritten before it can reach a window.
    always_ff @(posedge clk) begin
        if (bus.in_valid) begin
            lb1_q[col] <= lb0_q[col];
            lb0_q[col] <= bus.in_pix;
        end
    end

    always_comb begin
        win_flat = '0;
        for (int c = 0; c < CH; c++)
            for (int k = 0; k < 9; k++)
                win_flat[c*9*ACT_W + k*ACT_W +: ACT_W] = win_q[k/3][k%3][c*ACT_W +: ACT_W];
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.out_win    = win_flat;
endmodule

// File: tb/tb_dw_window_gen_3x3.sv
// tb_dw_window_gen_3x3: image-array reference model plus table and hand-written corner sequences.
module tb_dw_window_gen_3x3;
    localparam int CH = 16, AW = 8, W = 8, H = 8;
    localparam int PW = CH * AW, WW = 9 * PW;

    typedef struct {
        int          n;
        logic [71:0] taps;
        logic        fd;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dw_window_gen_3x3_if #(.CH(CH), .ACT_W(AW)) bus ();
    dw_window_gen_3x3 #(.CH(CH), .ACT_W(AW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int            checks = 0, failures = 0;
    logic [PW-1:0] img [H][W];
    int            mr, mc, nwin, nfd;
    logic [WW-1:0] prev_win;
    logic [WW-1:0] cap_win [$];
    logic          cap_fd [$];
    vec_t          tbl [4];

    task automatic chkv(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chkw(string name, logic [WW-1:0] act, logic [WW-1:0] exp);
        int c;
        checks++;
        if (act !== exp) begin
            failures++;
            for (c = 0; c < CH - 1; c++)
                if (act[c*72 +: 72] !== exp[c*72 +: 72]) break;
            $display("FAIL %s ch%0d actual=%h required=%h", name, c, act[c*72 +: 72], exp[c*72 +: 72]);
        end
    endtask

    // Window expected from the stored image: rows r-2..r, cols c-2..c.
    function automatic logic [WW-1:0] exp_win(int r, int c);
        logic [WW-1:0] w = '0;
        for (int ch = 0; ch < CH; ch++)
            for (int k = 0; k < 9; k++)
                w[ch*9*AW + k*AW +: AW] = img[r-2+k/3][c-2+k%3][ch*AW +: AW];
        return w;
    endfunction

    function automatic logic [PW-1:0] pat(int mode, int r, int c);
        logic [PW-1:0] p;
        for (int ch = 0; ch < CH; ch++)
            p[ch*AW +: AW] = mode == 0 ? 8'(r*8 + c) :
                             mode == 1 ? 8'(16*ch + ((r*8 + c) & 15)) :
                             mode == 2 ? 8'($urandom) : 8'(128 + r*8 + c);
        return p;
    endfunction

    task automatic step(bit v, bit sof, logic [PW-1:0] pix);
        logic          ev = 1'b0, efd = 1'b0;
        logic [WW-1:0] ew = '0;
        int            r, c;
        bus.in_valid = v;
        bus.in_sof   = sof;
        bus.in_pix   = pix;
        if (v) begin
            r = sof ? 0 : mr;
            c = sof ? 0 : mc;
            img[r][c] = pix;
            if (r >= 2 && c >= 2) begin
                ev  = 1'b1;
                ew  = exp_win(r, c);
                efd = r == H - 1 && c == W - 1;
            end
            mc = c == W - 1 ? 0 : c + 1;
            mr = c == W - 1 ? (r == H - 1 ? 0 : r + 1) : r;
        end
        @(posedge clk);
        #1;
        chkv("out_valid", 64'(bus.out_valid), 64'(ev));
        chkv("frame_done", 64'(bus.frame_done), 64'(efd));
        if (ev) chkw("out_win", bus.out_win, ew);
        else if (!v) chkw("out_win_hold", bus.out_win, prev_win);
        if (bus.out_valid) begin
            nwin++;
            cap_win.push_back(bus.out_win);
            cap_fd.push_back(bus.frame_done);
        end
        if (bus.frame_done) nfd++;
        prev_win = bus.out_win;
    endtask

    task automatic run_frame(int mode, bit gaps, bit sof_first, int npix);
        for (int i = 0; i < npix; i++) begin
            if (gaps) begin
                int ng = $urandom_range(0, 2);
                for (int g = 0; g < ng; g++) step(1'b0, 1'b0, '0);
            end
            step(1'b1, sof_first && i == 0, pat(mode, i / W, i % W));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chkv("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chkv("rst_frame_done", 64'(bus.frame_done), 64'd0);
        chkw("rst_out_win", bus.out_win, '0);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        mr       = 0;
        mc       = 0;
        prev_win = '0;
    endtask

    task automatic clear_counts();
        nwin = 0;
        nfd  = 0;
        cap_win.delete();
        cap_fd.delete();
    endtask

    initial begin
        logic [7:0] low [9] = '{0, 1, 2, 8, 9, 10, 0, 1, 2};
        logic [71:0] ef;
        tbl[0] = '{0,  {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0}, 1'b0};
        tbl[1] = '{5,  {8'd23, 8'd22, 8'd21, 8'd15, 8'd14, 8'd13, 8'd7, 8'd6, 8'd5}, 1'b0};
        tbl[2] = '{6,  {8'd26, 8'd25, 8'd24, 8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8}, 1'b0};
        tbl[3] = '{35, {8'd63, 8'd62, 8'd61, 8'd55, 8'd54, 8'd53, 8'd47, 8'd46, 8'd45}, 1'b1};
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_pix   = '0;
        #2;
        do_reset();

        // Ramp frame, continuous beats, checked against the tap table.
        clear_counts();
        run_frame(0, 1'b0, 1'b0, 64);
        chkv("t1_windows", 64'(nwin), 64'd36);
        chkv("t1_frame_done", 64'(nfd), 64'd1);
        foreach (tbl[i]) begin
            if (cap_win.size() > tbl[i].n) begin
                chkv("t1_taps", cap_win[tbl[i].n][63:0], tbl[i].taps[63:0]);
                chkv("t1_tap8", 64'(cap_win[tbl[i].n][71:64]), 64'(tbl[i].taps[71:64]));
                chkv("t1_fd", 64'(cap_fd[tbl[i].n]), 64'(tbl[i].fd));
            end else chkv("t1_missing_window", 64'(cap_win.size()), 64'(tbl[i].n + 1));
        end

        // Same frame with random idle gaps.
        clear_counts();
        run_frame(0, 1'b1, 1'b0, 64);
        step(1'b0, 1'b0, '0);
        chkv("t2_windows", 64'(nwin), 64'd36);
        chkv("t2_frame_done", 64'(nfd), 64'd1);

        // Channel ordering: each channel carries its own 16*c offset.
        clear_counts();
        run_frame(1, 1'b0, 1'b0, 64);
        if (cap_win.size() > 0)
            for (int c = 0; c < CH; c++) begin
                for (int k = 0; k < 9; k++) ef[k*8 +: 8] = 8'(16*c) + low[k];
                chkv("t3_chan", cap_win[0][c*72 +: 64], ef[63:0]);
            end
        else chkv("t3_missing_window", 64'd0, 64'd1);

        // Mid-frame sof abandons frame A.
        run_frame(3, 1'b0, 1'b0, 30);
        clear_counts();
        run_frame(0, 1'b0, 1'b1, 64);
        chkv("t4_windows", 64'(nwin), 64'd36);
        chkv("t4_frame_done", 64'(nfd), 64'd1);

        // Reset mid-row 4 while a window is being presented.
        clear_counts();
        run_frame(0, 1'b0, 1'b0, 36);
        bus.in_valid = 1'b1;
        bus.in_pix   = pat(0, 4, 4);
        #2;
        do_reset();
        clear_counts();
        run_frame(0, 1'b0, 1'b0, 64);
        chkv("t5_windows", 64'(nwin), 64'd36);
        chkv("t5_frame_done", 64'(nfd), 64'd1);
        if (cap_win.size() > 0) chkv("t5_first_taps", cap_win[0][63:0], tbl[0].taps[63:0]);

        // Two back-to-back random frames, no sof on either.
        clear_counts();
        run_frame(2, 1'b0, 1'b0, 64);
        run_frame(2, 1'b1, 1'b0, 64);
        step(1'b0, 1'b0, '0);
        chkv("t6_windows", 64'(nwin), 64'd72);
        chkv("t6_frame_done", 64'(nfd), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
